// File: rtl/vec_cap_pkg.sv
// Shared types for the vector capture scheduler: record kinds, session states
// and the per-cycle push request formed by the scheduler.
package vec_cap_pkg;

  localparam int SRC_ID_W = 8;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_HDR  = 2'b01,
    KIND_DATA = 2'b10,
    KIND_OVF  = 2'b11
  } rec_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_RUN,
    ST_DRAIN
  } cap_state_e;

  typedef struct packed {
    logic      push;
    rec_kind_e kind;
  } rec_req_t;

endpackage

// File: rtl/vec_cap_fifo.sv
// Synchronous record FIFO with full/empty flags; the head entry is read straight
// from storage flops and forced to zero while the FIFO is empty.
module vec_cap_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/vec_capture_sched.sv
// Capture session scheduler: emits HDR, timestamped DATA samples and OVF drop
// reports into a record FIFO. Define VEC_CAP_CHANGE_ONLY_EN to log only changes.
module vec_capture_sched
  import vec_cap_pkg::*;
#(
  parameter int                  VEC_W  = 3,
  parameter int                  TS_W   = 16,
  parameter int                  DEPTH  = 8,
  parameter logic [SRC_ID_W-1:0] SRC_ID = 8'h00
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic [VEC_W-1:0] vec,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [1:0]       rec_kind,
  output logic [TS_W-1:0]  rec_ts,
  output logic [VEC_W-1:0] rec_vec,
  output logic             busy,
  output logic             overflow
);

  localparam int REC_W = 2 + TS_W + VEC_W;

  cap_state_e      state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] drop_q, drop_d;
  logic [TS_W-1:0] drop_inc;
  logic            overflow_q, overflow_d;
  logic            sample_want;
  rec_req_t        req;
  logic [TS_W-1:0] push_ts;
  logic [VEC_W-1:0] push_vec;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [REC_W-1:0] fifo_head;
`ifdef VEC_CAP_CHANGE_ONLY_EN
  logic             first_q, first_d;
  logic [VEC_W-1:0] last_vec_q, last_vec_d;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start && !stop) state_d = ST_HEADER;
      ST_HEADER: state_d = stop ? ST_DRAIN : ST_RUN;
      ST_RUN:    if (stop) state_d = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty && (drop_q == '0)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req        = '{push: 1'b0, kind: KIND_NONE};
    push_ts    = '0;
    push_vec   = '0;
    ts_d       = ts_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    drop_inc   = (&drop_q) ? drop_q : drop_q + TS_W'(1);
`ifdef VEC_CAP_CHANGE_ONLY_EN
    first_d     = first_q;
    last_vec_d  = last_vec_q;
    sample_want = first_q || (vec != last_vec_q);
`else
    sample_want = 1'b1;
`endif
    case (state_q)
      ST_HEADER: begin
        req     = '{push: 1'b1, kind: KIND_HDR};
        push_ts = TS_W'(SRC_ID);
        ts_d    = '0;
`ifdef VEC_CAP_CHANGE_ONLY_EN
        first_d = 1'b1;
`endif
      end
      ST_RUN: begin
        ts_d = ts_q + TS_W'(1);
`ifdef VEC_CAP_CHANGE_ONLY_EN
        first_d    = 1'b0;
        last_vec_d = vec;
`endif
        // A pending OVF takes this cycle's slot; the displaced sample joins its count.
        if ((drop_q != '0) && !fifo_full) begin
          req     = '{push: 1'b1, kind: KIND_OVF};
          push_ts = sample_want ? drop_inc : drop_q;
          drop_d  = '0;
        end else if (sample_want) begin
          if (fifo_full) begin
            drop_d     = drop_inc;
            overflow_d = 1'b1;
          end else begin
            req      = '{push: 1'b1, kind: KIND_DATA};
            push_ts  = ts_q;
            push_vec = vec;
          end
        end
      end
      ST_DRAIN: begin
        if ((drop_q != '0) && !fifo_full) begin
          req     = '{push: 1'b1, kind: KIND_OVF};
          push_ts = drop_q;
          drop_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ts_q       <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
`ifdef VEC_CAP_CHANGE_ONLY_EN
      first_q    <= 1'b0;
      last_vec_q <= '0;
`endif
    end else begin
      ts_q       <= ts_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
`ifdef VEC_CAP_CHANGE_ONLY_EN
      first_q    <= first_d;
      last_vec_q <= last_vec_d;
`endif
    end
  end

  assign rec_valid = !fifo_empty;
  assign fifo_pop  = rec_valid && rec_ready;

  vec_cap_fifo #(
    .W    (REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push     (req.push),
    .push_data({req.kind, push_ts, push_vec}),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign {rec_kind, rec_ts, rec_vec} = fifo_head;
  assign busy     = (state_q != ST_IDLE);
  assign overflow = overflow_q;

endmodule

// File: doc/vec_capture_sched.md
VEC_CAPTURE_SCHED -- requirements
Module: vec_capture_sched

Interface
REQ-001 SHALL have parameter VEC_W, default 3, width of the captured signal vector.
REQ-002 SHALL have parameter TS_W, default 16, timestamp width; legal range is 8 or more.
REQ-003 SHALL have parameter DEPTH, default 8, record FIFO depth; legal values are powers of 2, 2 or more.
REQ-004 SHALL have parameter SRC_ID, default 8'h00, source identifier carried in the header record.
REQ-005 SHALL have port: Clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port: Reset  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port: start  in  1  single-cycle pulse that begins a capture session.
REQ-008 SHALL have port: stop  in  1  single-cycle pulse that ends the session.
REQ-009 SHALL have port: vec  in  VEC_W  signals sampled each cycle.
REQ-010 SHALL have port: rec_valid  out  1  record available.
REQ-011 SHALL have port: rec_ready  in  1  sink accepts the record.
REQ-012 SHALL have port: rec_kind  out  2  record type: HDR=01, DATA=10, OVF=11.
REQ-013 SHALL have port: rec_ts  out  TS_W  timestamp, SRC_ID or drop count, per kind.
REQ-014 SHALL have port: rec_vec  out  VEC_W  sampled vector; 0 for HDR and OVF.
REQ-015 SHALL have port: busy  out  1  high whenever state is not IDLE.
REQ-016 SHALL have port: overflow  out  1  sticky; set on any dropped sample.

Function
REQ-017 SHALL implement states IDLE, HEADER, RUN, DRAIN.
REQ-018 SHALL move IDLE to HEADER on start; start SHALL be ignored in every other state.
REQ-019 SHALL, in HEADER, push one HDR record (rec_ts = SRC_ID zero-extended) for exactly 1 cycle, then go to RUN.
REQ-020 SHALL clear the timestamp counter to 0 on entry to RUN and increment it every RUN cycle, wrapping modulo 2^TS_W.
REQ-021 SHALL, in RUN, form a DATA record each cycle as {ts, vec}, with timestamp 0 on the first RUN cycle.
REQ-022 SHALL evaluate FIFO full at the start of the cycle; a push SHALL be refused while full, even if a pop occurs in that same cycle.
REQ-023 SHALL, on a refused push, drop the sample, increment the drop counter (TS_W bits, saturating at all-ones), and set overflow.
REQ-024 SHALL, when drop count > 0 and the FIFO is not full, push an OVF record in place of that cycle's sample. The replaced sample SHALL be counted in the OVF value, and the drop counter SHALL then clear.
REQ-025 SHALL present the FIFO head on rec_* registered, so a sample taken in cycle N is visible no earlier than cycle N+1.
REQ-026 SHALL hold rec_valid and rec_kind/rec_ts/rec_vec stable until rec_valid and rec_ready are both high; a pop SHALL occur only on that condition.
REQ-027 SHALL move to DRAIN on stop in RUN. A stop in HEADER SHALL still emit HDR and then enter DRAIN. A pending OVF SHALL be pushed in DRAIN once space exists.
REQ-028 SHALL stop sampling in DRAIN and go to IDLE in the cycle after the FIFO becomes empty with no OVF pending.
REQ-029 SHALL let stop take priority over start in the same cycle; both pulses in IDLE SHALL leave the block in IDLE.

Reset
REQ-030 SHALL, on Reset high at a rising Clk edge, force IDLE, empty the FIFO, and zero the timestamp and drop counter.
REQ-031 SHALL drive rec_valid=0, busy=0, overflow=0, rec_kind=0, rec_ts=0, rec_vec=0 in the cycle after reset, including when reset occurs mid-session or mid-handshake.
REQ-032 SHALL give Reset priority over start, stop and rec_ready.

Configuration
REQ-033 SHALL, with macro VEC_CAP_CHANGE_ONLY_EN defined, push a DATA record only when vec differs from the last sampled vec, or on the first RUN cycle.
REQ-034 SHALL compare change-only samples against the last sampled value, including dropped samples.
REQ-035 SHALL, with VEC_CAP_CHANGE_ONLY_EN undefined, push a DATA record every RUN cycle.

Structure
REQ-036 SHALL place the kind constants (HDR/DATA/OVF), the state enum and the record struct in package vec_cap_pkg.
REQ-037 SHALL implement the storage as sub-module vec_cap_fifo: synchronous, DEPTH entries, full/empty flags, registered head.

Verification
REQ-038 SHALL cover basic capture. Config: SRC_ID=8'h5A, macro off. Stimulus: start, vec=3'b101, rec_ready=1. Response: HDR ts=0x005A, then DATA ts=0,1,2... with vec=101.
REQ-039 SHALL cover backpressure. Config: DEPTH=8. Stimulus: rec_ready=0 for RUN cycles 0-19, then 1. Response: 8 records emitted (HDR + DATA ts 0-6), then OVF ts=15, then DATA ts=22; overflow=1.
REQ-040 SHALL cover change-only mode. Config: macro on. Stimulus: vec=000 for 5 cycles, then 011. Response: DATA ts=0 vec=000 and DATA ts=5 vec=011 only.
REQ-041 SHALL cover stop with queued records. Stimulus: stop with 3 records queued and rec_ready=0, then rec_ready=1; start pulsed during DRAIN. Response: 3 records drained, busy falls 1 cycle after empty, the start is ignored.
REQ-042 SHALL cover reset mid-handshake. Stimulus: Reset during RUN with rec_valid=1 and rec_ready=0. Response: next cycle rec_valid=0, busy=0, overflow=0.
REQ-043 SHALL cover timestamp wrap. Config: TS_W=8. Stimulus: 300 RUN cycles. Response: DATA ts 255 is followed by ts 0.
